softreg_manager_param: RTL and testbench

- Parametrised host soft-register manager between the PCIe shell soft-register port and the application.
- Decodes four address windows:
  - a read-only status window fed by arbitrary design counters;
  - a read/write control register bank with per-register write strobes;
  - a diagnostic counter window;
  - a pass-through window forwarded to the user soft-register port.
- Adds a bounded wait on user reads (timeout with a poison response) and accounting of dropped and late transactions.

---
 rtl/softreg_manager_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_softreg_manager_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softreg_manager_param.sv
// Host soft-register manager: decodes status, control, diagnostic and user windows
// of the shell soft-register port, with a bounded wait on user reads.
package softreg_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } softreg_req_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } softreg_resp_t;
endpackage

module softreg_manager_param
    import softreg_pkg::*;
#(
    parameter int          NUM_STATUS   = 32,
    parameter int          STATUS_BASE  = 100,
    parameter int          NUM_CTRL     = 8,
    parameter int          CTRL_BASE    = 64,
    parameter logic [63:0] CTRL_RESET   = 64'h0,
    parameter int          DIAG_BASE    = 96,
    parameter int          USER_BASE    = 200,
    parameter int          USER_TIMEOUT = 1024,
    parameter logic [63:0] TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  softreg_req_t        softreg_req,
    output softreg_resp_t       softreg_resp,
    output softreg_req_t        user_softreg_req,
    input  softreg_resp_t       user_softreg_resp,
    input  logic [63:0]         status_in [NUM_STATUS],
    output logic [63:0]         ctrl_out [NUM_CTRL],
    output logic [NUM_CTRL-1:0] ctrl_wr,
    output logic                busy
);
    localparam int NUM_DIAG = 3;
    localparam int TW       = $clog2(USER_TIMEOUT);

    localparam logic [TW-1:0] TMO_LAST  = TW'(USER_TIMEOUT - 1);
    localparam logic [31:0]   USER_LO   = 32'(USER_BASE);
    localparam logic [31:0]   CTRL_LO   = 32'(CTRL_BASE);
    localparam logic [31:0]   CTRL_HI   = 32'(CTRL_BASE + NUM_CTRL);
    localparam logic [31:0]   DIAG_LO   = 32'(DIAG_BASE);
    localparam logic [31:0]   DIAG_HI   = 32'(DIAG_BASE + NUM_DIAG);
    localparam logic [31:0]   STATUS_LO = 32'(STATUS_BASE);
    localparam logic [31:0]   STATUS_HI = 32'(STATUS_BASE + NUM_STATUS);

    function automatic logic ranges_overlap(int a_base, int a_num, int b_base, int b_num);
        return (a_base < b_base + b_num) && (b_base < a_base + a_num);
    endfunction

    // Saturating diagnostic counter update; a clear beats a same-cycle increment.
    function automatic logic [31:0] diag_next(logic [31:0] cur, logic inc, logic clr);
        if (clr) begin
            return 32'h0;
        end else if (inc && (cur != 32'hFFFF_FFFF)) begin
            return cur + 32'd1;
        end else begin
            return cur;
        end
    endfunction

    localparam logic WIN_OVERLAP =
        ranges_overlap(CTRL_BASE, NUM_CTRL, DIAG_BASE, NUM_DIAG) ||
        ranges_overlap(CTRL_BASE, NUM_CTRL, STATUS_BASE, NUM_STATUS) ||
        ranges_overlap(DIAG_BASE, NUM_DIAG, STATUS_BASE, NUM_STATUS) ||
        (CTRL_BASE + NUM_CTRL > USER_BASE) ||
        (DIAG_BASE + NUM_DIAG > USER_BASE) ||
        (STATUS_BASE + NUM_STATUS > USER_BASE);

    generate
        if (WIN_OVERLAP) begin : g_window_overlap
            $error("softreg_manager_param: address windows overlap");
        end
        if (USER_TIMEOUT < 2) begin : g_timeout_range
            $error("softreg_manager_param: USER_TIMEOUT must be at least 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_r;
    logic [TW-1:0]       tmo_r;
    softreg_req_t        user_req_r;
    softreg_resp_t       resp_r;
    logic [63:0]         ctrl_r [NUM_CTRL];
    logic [NUM_CTRL-1:0] ctrl_wr_r;
    logic [31:0]         diag_cnt_r [NUM_DIAG];

    logic                busy_s;
    logic                rd_s;
    logic                wr_s;
    logic                user_hit_s;
    logic                ctrl_hit_s;
    logic                diag_hit_s;
    logic                status_hit_s;
    logic [31:0]         ctrl_off_s;
    logic [31:0]         diag_off_s;
    logic [31:0]         status_off_s;
    logic                fwd_s;
    logic                user_rd_s;
    logic                int_rd_s;
    logic                drop_s;
    logic                user_done_s;
    logic                expire_s;
    logic                late_s;
    logic [NUM_DIAG-1:0] diag_inc_s;
    logic [63:0]         rd_data_s;
    logic [63:0]         resp_data_s;

    assign busy_s       = (state_r == ST_WAIT);
    assign rd_s         = softreg_req.valid && !softreg_req.is_write;
    assign wr_s         = softreg_req.valid && softreg_req.is_write;

    assign user_hit_s   = (softreg_req.addr >= USER_LO);
    assign ctrl_hit_s   = !user_hit_s && (softreg_req.addr >= CTRL_LO) && (softreg_req.addr < CTRL_HI);
    assign diag_hit_s   = !user_hit_s && !ctrl_hit_s &&
                          (softreg_req.addr >= DIAG_LO) && (softreg_req.addr < DIAG_HI);
    assign status_hit_s = !user_hit_s && !ctrl_hit_s && !diag_hit_s &&
                          (softreg_req.addr >= STATUS_LO) && (softreg_req.addr < STATUS_HI);
    assign ctrl_off_s   = softreg_req.addr - CTRL_LO;
    assign diag_off_s   = softreg_req.addr - DIAG_LO;
    assign status_off_s = softreg_req.addr - STATUS_LO;

    // User writes always pass; user reads only when no read is outstanding.
    assign fwd_s        = softreg_req.valid && user_hit_s && (softreg_req.is_write || !busy_s);
    assign user_rd_s    = rd_s && user_hit_s && !busy_s;
    assign int_rd_s     = rd_s && !user_hit_s && !busy_s;
    assign drop_s       = rd_s && busy_s;
    assign user_done_s  = busy_s && user_softreg_resp.valid;
    assign expire_s     = busy_s && !user_softreg_resp.valid && (tmo_r == TMO_LAST);
    assign late_s       = !busy_s && user_softreg_resp.valid;
    assign diag_inc_s   = {late_s, drop_s, expire_s};

    // Internal read mux; at most one term is selected, unmapped reads give zero.
    always_comb begin
        rd_data_s = 64'h0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            rd_data_s = rd_data_s | ({64{ctrl_hit_s && (ctrl_off_s == 32'(i))}} & ctrl_r[i]);
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            rd_data_s = rd_data_s | ({64{status_hit_s && (status_off_s == 32'(i))}} & status_in[i]);
        end
        for (int i = 0; i < NUM_DIAG; i++) begin
            rd_data_s = rd_data_s |
                        ({64{diag_hit_s && (diag_off_s == 32'(i))}} & {32'h0, diag_cnt_r[i]});
        end
    end

    // Host response data source selection.
    always_comb begin
        if (user_done_s) begin
            resp_data_s = user_softreg_resp.data;
        end else if (expire_s) begin
            resp_data_s = TIMEOUT_DATA;
        end else if (int_rd_s) begin
            resp_data_s = rd_data_s;
        end else begin
            resp_data_s = 64'h0;
        end
    end

    // User forwarding register, outstanding-read wait state and host response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tmo_r      <= '0;
            user_req_r <= '0;
            resp_r     <= '0;
        end else begin
            user_req_r.valid    <= fwd_s;
            user_req_r.is_write <= softreg_req.is_write;
            user_req_r.addr     <= softreg_req.addr;
            user_req_r.data     <= softreg_req.data;
            resp_r.valid        <= int_rd_s || user_done_s || expire_s;
            resp_r.data         <= resp_data_s;
            case (state_r)
                ST_IDLE: begin
                    if (user_rd_s) begin
                        state_r <= ST_WAIT;
                        tmo_r   <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                        tmo_r   <= tmo_r;
                    end
                end
                ST_WAIT: begin
                    if (user_done_s || expire_s) begin
                        state_r <= ST_IDLE;
                        tmo_r   <= tmo_r;
                    end else begin
                        state_r <= ST_WAIT;
                        tmo_r   <= tmo_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tmo_r   <= '0;
                end
            endcase
        end
    end

    // Control register bank with one-cycle write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_r[i] <= CTRL_RESET;
            end
            ctrl_wr_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (wr_s && ctrl_hit_s && (ctrl_off_s == 32'(i))) begin
                    ctrl_r[i]    <= softreg_req.data;
                    ctrl_wr_r[i] <= 1'b1;
                end else begin
                    ctrl_r[i]    <= ctrl_r[i];
                    ctrl_wr_r[i] <= 1'b0;
                end
            end
        end
    end

    // Diagnostic counters: timeouts, dropped reads, late user responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIAG; i++) begin
                diag_cnt_r[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < NUM_DIAG; i++) begin
                diag_cnt_r[i] <= diag_next(diag_cnt_r[i], diag_inc_s[i],
                                           wr_s && diag_hit_s && (diag_off_s == 32'(i)));
            end
        end
    end

    assign softreg_resp     = resp_r;
    assign user_softreg_req = user_req_r;
    assign ctrl_out         = ctrl_r;
    assign ctrl_wr          = ctrl_wr_r;
    assign busy             = busy_s;

endmodule

// File: tb/tb_softreg_manager_param.sv
// Randomised scoreboard bench for softreg_manager_param against a cycle-level
// reference model of the register windows and the user-read wait.
module tb_softreg_manager_param;
    import softreg_pkg::*;

    localparam int          NS = 32;
    localparam int          NC = 8;
    localparam int          UT = 16;
    localparam logic [63:0] CR = 64'h5;
    localparam logic [63:0] TD = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [31:0] CB = 32'd64;
    localparam logic [31:0] DB = 32'd96;
    localparam logic [31:0] SB = 32'd100;
    localparam logic [31:0] UB = 32'd200;

    logic          clk = 1'b0;
    logic          rst;
    softreg_req_t  softreg_req;
    softreg_resp_t softreg_resp;
    softreg_req_t  user_softreg_req;
    softreg_resp_t user_softreg_resp;
    logic [63:0]   status_in [NS];
    logic [63:0]   ctrl_out [NC];
    logic [NC-1:0] ctrl_wr;
    logic          busy;

    softreg_manager_param #(
        .NUM_STATUS(NS), .STATUS_BASE(100), .NUM_CTRL(NC), .CTRL_BASE(64),
        .CTRL_RESET(CR), .DIAG_BASE(96), .USER_BASE(200), .USER_TIMEOUT(UT),
        .TIMEOUT_DATA(TD)
    ) dut (
        .clk(clk), .rst(rst),
        .softreg_req(softreg_req), .softreg_resp(softreg_resp),
        .user_softreg_req(user_softreg_req), .user_softreg_resp(user_softreg_resp),
        .status_in(status_in), .ctrl_out(ctrl_out), .ctrl_wr(ctrl_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [63:0]   ctrl_m [NC];
    logic [31:0]   diag_m [3];
    bit            pend;
    int            busy_from;
    int            deadline;
    logic [NC-1:0] exp_wr;
    bit            exp_uv;
    softreg_req_t  exp_ureq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) ctrl_m[i] = CR;
        for (int i = 0; i < 3; i++) diag_m[i] = 32'h0;
        pend   = 1'b0;
        exp_wr = '0;
        exp_uv = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [63:0] ref_read(input logic [31:0] a);
        if (a >= CB && a < CB + 32'd8) return ctrl_m[int'(a - CB)];
        if (a >= DB && a < DB + 32'd3) return {32'h0, diag_m[int'(a - DB)]};
        if (a >= SB && a < SB + 32'd32) return status_in[int'(a - SB)];
        return 64'h0;
    endfunction

    // One bus cycle: check the outputs this cycle shows, drive the request,
    // and advance the model to what the next cycle must show.
    task automatic do_cycle(input bit v, input bit w, input logic [31:0] a, input logic [63:0] d,
                            input bit uv, input logic [63:0] ud);
        bit         busy_now;
        logic [2:0] inc;
        logic [2:0] clr;
        exp_t       e;
        busy_now = pend && (cyc >= busy_from);
        chk("busy", 64'(busy), 64'(busy_now));
        chk("ctrl_wr", 64'(ctrl_wr), 64'(exp_wr));
        for (int i = 0; i < NC; i++) chk($sformatf("ctrl_out[%0d]", i), ctrl_out[i], ctrl_m[i]);
        chk("ureq_valid", 64'(user_softreg_req.valid), 64'(exp_uv));
        if (exp_uv) begin
            chk("ureq_is_write", 64'(user_softreg_req.is_write), 64'(exp_ureq.is_write));
            chk("ureq_addr", 64'(user_softreg_req.addr), 64'(exp_ureq.addr));
            chk("ureq_data", user_softreg_req.data, exp_ureq.data);
        end

        softreg_req.valid      = v;
        softreg_req.is_write   = w;
        softreg_req.addr       = a;
        softreg_req.data       = d;
        user_softreg_resp.valid = uv;
        user_softreg_resp.data  = ud;

        inc    = 3'b000;
        clr    = 3'b000;
        exp_wr = '0;
        exp_uv = 1'b0;
        if (v && a >= UB) begin
            if (w || !busy_now) begin
                exp_uv   = 1'b1;
                exp_ureq = softreg_req;
            end
            if (!w && busy_now) begin
                inc[1] = 1'b1;
            end else if (!w) begin
                pend      = 1'b1;
                busy_from = cyc + 1;
                deadline  = cyc + UT;
            end
        end else if (v && !w && busy_now) begin
            inc[1] = 1'b1;
        end else if (v && !w) begin
            e.data = ref_read(a);
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end else if (v && w) begin
            if (a >= CB && a < CB + 32'd8) begin
                ctrl_m[int'(a - CB)] = d;
                exp_wr[int'(a - CB)] = 1'b1;
            end else if (a >= DB && a < DB + 32'd3) begin
                clr[int'(a - DB)] = 1'b1;
            end
        end

        if (busy_now && uv) begin
            e.data = ud;
            e.due  = cyc + 1;
            exp_q.push_back(e);
            pend = 1'b0;
        end else if (busy_now && cyc == deadline) begin
            e.data = TD;
            e.due  = cyc + 1;
            exp_q.push_back(e);
            inc[0] = 1'b1;
            pend   = 1'b0;
        end else if (!busy_now && uv) begin
            inc[2] = 1'b1;
        end

        for (int i = 0; i < 3; i++) begin
            if (clr[i]) diag_m[i] = 32'h0;
            else if (inc[i] && diag_m[i] != 32'hFFFF_FFFF) diag_m[i] = diag_m[i] + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 64'd0);
    endtask

    // Response monitor: every host response must match the oldest expectation, on time.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (softreg_resp.valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_valid_unexpected", 64'(softreg_resp.valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", softreg_resp.data, e.data);
                    chk("resp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                chk("resp_valid_missing", 64'(softreg_resp.valid), 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst               = 1'b1;
        softreg_req       = '0;
        user_softreg_resp = '0;
        for (int i = 0; i < NS; i++) status_in[i] = 64'(i) * 64'h1111_0000_0101;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_resp_valid", 64'(softreg_resp.valid), 64'd0);
        chk("reset_ureq_valid", 64'(user_softreg_req.valid), 64'd0);
        chk("reset_ctrl_out0", ctrl_out[0], 64'h5);
        rst = 1'b0;

        // Control write/readback
        do_cycle(1'b1, 1'b1, 32'd66, 64'hA5, 1'b0, 64'd0);
        chk("ctrl_wr_pulse", 64'(ctrl_wr), 64'h04);
        chk("ctrl_out2", ctrl_out[2], 64'hA5);
        do_cycle(1'b1, 1'b0, 32'd66, 64'd0, 1'b0, 64'd0);
        idle(1);

        // Status and unmapped reads
        status_in[7] = 64'h1234;
        do_cycle(1'b1, 1'b0, 32'd107, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b1, 1'b0, 32'd99, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b1, 1'b0, 32'd90, 64'd0, 1'b0, 64'd0);
        idle(1);

        // User read answered after 5 cycles
        do_cycle(1'b1, 1'b0, 32'd250, 64'd0, 1'b0, 64'd0);
        idle(4);
        do_cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 64'hCAFE);
        idle(2);

        // User read timeout, then a late response
        do_cycle(1'b1, 1'b0, 32'd250, 64'd0, 1'b0, 64'd0);
        idle(UT + 2);
        do_cycle(1'b1, 1'b0, 32'd96, 64'd0, 1'b0, 64'd0);
        idle(2);
        do_cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 64'h77);
        do_cycle(1'b1, 1'b0, 32'd98, 64'd0, 1'b0, 64'd0);
        idle(1);

        // Dropped read and accepted control write while busy, then diag clear
        do_cycle(1'b1, 1'b0, 32'd250, 64'd0, 1'b0, 64'd0);
        idle(1);
        do_cycle(1'b1, 1'b0, 32'd107, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b1, 1'b1, 32'd64, 64'h9, 1'b0, 64'd0);
        do_cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 64'h1357);
        idle(1);
        do_cycle(1'b1, 1'b0, 32'd97, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b1, 1'b1, 32'd97, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b1, 1'b0, 32'd97, 64'd0, 1'b0, 64'd0);
        idle(2);

        // Asynchronous reset in the middle of an outstanding user read
        do_cycle(1'b1, 1'b0, 32'd250, 64'd0, 1'b0, 64'd0);
        idle(2);
        rst = 1'b1;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_resp_valid", 64'(softreg_resp.valid), 64'd0);
        chk("midreset_ureq_valid", 64'(user_softreg_req.valid), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 64'h4242);
        do_cycle(1'b1, 1'b0, 32'd98, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b1, 1'b0, 32'd96, 64'd0, 1'b0, 64'd0);
        idle(1);

        // Randomised traffic across all windows
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            int          cat;
            if ($urandom_range(0, 15) == 0) status_in[$urandom_range(0, NS - 1)] = {$urandom, $urandom};
            cat = int'($urandom_range(0, 6));
            case (cat)
                0: a = 32'(64 + $urandom_range(0, 7));
                1: a = 32'(96 + $urandom_range(0, 2));
                2: a = 32'(100 + $urandom_range(0, 31));
                3: a = 32'($urandom_range(0, 63));
                4: a = 32'(72 + $urandom_range(0, 27) + (($urandom_range(0, 1) == 1) ? 60 : 0));
                5: a = 32'(200 + $urandom_range(0, 1000));
                default: a = $urandom | 32'h8000_0000;
            endcase
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, {$urandom, $urandom},
                     $urandom_range(0, 9) == 0, {$urandom, $urandom});
        end

        idle(UT + 4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
